// File: rtl/bpu_pkg.sv
// Shared constants, target-mode encodings and the buffered prediction entry.
package bpu_pkg;

    localparam int unsigned DEF_SLOTS      = 16;
    localparam int unsigned DEF_CNT_W      = 2;
    localparam int unsigned DEF_PC_W       = 64;
    localparam int unsigned DEF_TGT_W      = 32;
    localparam int unsigned DEF_INST_BYTES = 4;

    localparam int unsigned TGT_MODE_ZEXT   = 0;
    localparam int unsigned TGT_MODE_CONCAT = 1;

    // Entry fields are sized for the widest legal configuration (PC_W <= 64, SLOTS <= 32).
    localparam int unsigned PC_MAX_W   = 64;
    localparam int unsigned SLOT_MAX_W = 5;

    typedef struct packed {
        logic [PC_MAX_W-1:0]   base_pc;
        logic [PC_MAX_W-1:0]   trigger_pc;
        logic [PC_MAX_W-1:0]   target;
        logic                  taken;
        logic [SLOT_MAX_W-1:0] slot;
    } pred_entry_t;

endpackage

// File: rtl/bpu_first_taken_enc.sv
// Finds the lowest slot at or after the start slot whose counter predicts taken.
module bpu_first_taken_enc #(
    parameter int unsigned SLOTS = 16,
    parameter int unsigned CNT_W = 2,
    localparam int unsigned IDX_W = $clog2(SLOTS)
) (
    input  logic [SLOTS*CNT_W-1:0] bht_i,
    input  logic [IDX_W-1:0]       start_i,
    output logic                   found_o,
    output logic [IDX_W-1:0]       index_o
);

    // Weakly-taken threshold: counter value 2^(CNT_W-1).
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(1) << (CNT_W - 1);

    logic [SLOTS-1:0] elig;

    // Per-slot eligibility: live slot and counter in the taken half.
    for (genvar g = 0; g < SLOTS; g++) begin : g_elig
        assign elig[g] = (32'(start_i) <= 32'(g)) && (bht_i[g*CNT_W +: CNT_W] >= THRESH);
    end

    // Priority pick of the lowest eligible slot.
    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (elig[i] && !found_o) begin
                found_o = 1'b1;
                index_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bhtbtb_pred_stage.sv
// Prediction stage: scans a BHT/BTB read beat for the first taken slot and
// buffers the result in a 2-entry FIFO, counting consumed taken predictions.
module bhtbtb_pred_stage import bpu_pkg::*; #(
    parameter int unsigned SLOTS        = DEF_SLOTS,
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned PC_W         = DEF_PC_W,
    parameter int unsigned TGT_W        = DEF_TGT_W,
    parameter int unsigned INST_BYTES   = DEF_INST_BYTES,
    parameter int unsigned TGT_MODE     = TGT_MODE_ZEXT,
    parameter logic [31:0] STAT_RST_VAL = 32'h0,
    localparam int unsigned IDX_W = $clog2(SLOTS)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SLOTS*CNT_W-1:0] in_bht,
    input  logic [TGT_W-1:0]       in_btb_tgt,
    input  logic                   in_tag_hit,
    input  logic [PC_W-1:0]        in_pc,
    input  logic [IDX_W-1:0]       in_start_slot,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        out_base_pc,
    output logic [PC_W-1:0]        out_trigger_pc,
    output logic [PC_W-1:0]        out_target,
    output logic                   out_taken,
    output logic [IDX_W-1:0]       out_slot,
    output logic [31:0]            stat_taken_cnt
);

    logic             found;
    logic [IDX_W-1:0] idx;
    logic             taken;
    logic [PC_W-1:0]  trig_pc;
    logic [PC_W-1:0]  tgt_ext;
    pred_entry_t      new_entry;
    pred_entry_t      head;

    pred_entry_t mem_q [2];
    pred_entry_t mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  occ_q, occ_d;
    logic        rdy_q;
    logic [31:0] stat_q, stat_d;
    logic        push, pop;

    bpu_first_taken_enc #(
        .SLOTS (SLOTS),
        .CNT_W (CNT_W)
    ) u_enc (
        .bht_i   (in_bht),
        .start_i (in_start_slot),
        .found_o (found),
        .index_o (idx)
    );

    assign taken   = found & in_tag_hit;
    assign trig_pc = in_pc + PC_W'(idx) * PC_W'(INST_BYTES);

    // Target formation: region-relative targets borrow the base PC upper bits.
    if (TGT_MODE == TGT_MODE_CONCAT && TGT_W < PC_W) begin : g_tgt_cat
        assign tgt_ext = {in_pc[PC_W-1:TGT_W], in_btb_tgt};
    end else begin : g_tgt_zext
        assign tgt_ext = PC_W'(in_btb_tgt);
    end

    // Build the entry to buffer; not-taken beats carry only the base PC.
    always_comb begin
        new_entry         = '0;
        new_entry.base_pc = PC_MAX_W'(in_pc);
        if (taken) begin
            new_entry.trigger_pc = PC_MAX_W'(trig_pc);
            new_entry.target     = PC_MAX_W'(tgt_ext);
            new_entry.taken      = 1'b1;
            new_entry.slot       = SLOT_MAX_W'(idx);
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (occ_q != 2'd0);
    assign in_ready  = rdy_q & ~occ_q[1] & ~flush;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready & ~flush;

    assign out_base_pc    = PC_W'(head.base_pc);
    assign out_trigger_pc = PC_W'(head.trigger_pc);
    assign out_target     = PC_W'(head.target);
    assign out_taken      = head.taken;
    assign out_slot       = IDX_W'(head.slot);
    assign stat_taken_cnt = stat_q;

    // FIFO and counter next state; flush empties the FIFO but leaves the counter.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        stat_d   = stat_q;
        if (flush) begin
            occ_d    = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = new_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            occ_d = occ_q + 2'(push) - 2'(pop);
        end
        if (pop && head.taken && (stat_q != 32'hFFFF_FFFF)) begin
            stat_d = stat_q + 32'd1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
            rdy_q    <= 1'b0;
            stat_q   <= STAT_RST_VAL;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            rdy_q    <= 1'b1;
            stat_q   <= stat_d;
        end
    end

endmodule

// File: tb/tb_bhtbtb_pred_stage.sv
// Bench for bhtbtb_pred_stage: a zero-extend instance and a concatenate-target
// instance with a near-saturated counter share one stimulus stream.
module tb_bhtbtb_pred_stage;

    localparam logic [31:0] B_STAT_RST = 32'hFFFF_FFFE;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n, flush, in_valid, out_ready, in_tag_hit;
    logic [31:0] in_bht, in_btb_tgt;
    logic [63:0] in_pc;
    logic [3:0]  in_start_slot;

    logic        a_in_ready, a_out_valid, a_out_taken;
    logic [63:0] a_out_base_pc, a_out_trigger_pc, a_out_target;
    logic [3:0]  a_out_slot;
    logic [31:0] a_stat;
    logic        b_in_ready, b_out_valid, b_out_taken;
    logic [63:0] b_out_base_pc, b_out_trigger_pc, b_out_target;
    logic [3:0]  b_out_slot;
    logic [31:0] b_stat;

    bhtbtb_pred_stage u_dut_a (
        .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_ready(a_in_ready), .in_bht(in_bht), .in_btb_tgt(in_btb_tgt),
        .in_tag_hit(in_tag_hit), .in_pc(in_pc), .in_start_slot(in_start_slot),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_base_pc(a_out_base_pc),
        .out_trigger_pc(a_out_trigger_pc), .out_target(a_out_target),
        .out_taken(a_out_taken), .out_slot(a_out_slot), .stat_taken_cnt(a_stat)
    );

    bhtbtb_pred_stage #(
        .TGT_MODE(1), .STAT_RST_VAL(B_STAT_RST)
    ) u_dut_b (
        .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_ready(b_in_ready), .in_bht(in_bht), .in_btb_tgt(in_btb_tgt),
        .in_tag_hit(in_tag_hit), .in_pc(in_pc), .in_start_slot(in_start_slot),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_base_pc(b_out_base_pc),
        .out_trigger_pc(b_out_trigger_pc), .out_target(b_out_target),
        .out_taken(b_out_taken), .out_slot(b_out_slot), .stat_taken_cnt(b_stat)
    );

    typedef struct {
        logic [63:0] base;
        logic [63:0] trig;
        logic [63:0] tgt_a;
        logic [63:0] tgt_b;
        logic        taken;
        logic [3:0]  slot;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur_exp;
    int          checks = 0;
    int          passed = 0;
    logic [31:0] stat_a_m, stat_b_m;
    logic        rst_done_m;
    logic        accepted;
    logic [63:0] held_base;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Reference prediction for one beat, written straight from the behaviour.
    function automatic exp_t model(input logic [63:0] pc, input logic [31:0] bht,
                                   input logic [3:0] start, input logic hit,
                                   input logic [31:0] tgt);
        exp_t        e;
        logic        found;
        logic [31:0] c;
        e.base  = pc;
        e.trig  = '0;
        e.tgt_a = '0;
        e.tgt_b = '0;
        e.taken = 1'b0;
        e.slot  = '0;
        found   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            c = (bht >> (2 * i)) & 32'h3;
            if (hit && !found && (i >= int'(start)) && (c >= 32'd2)) begin
                found   = 1'b1;
                e.taken = 1'b1;
                e.slot  = 4'(i);
                e.trig  = pc + 64'(i * 4);
                e.tgt_a = {32'h0, tgt};
                e.tgt_b = {pc[63:32], tgt};
            end
        end
        return e;
    endfunction

    // One clock: check state, score handshakes, step the model across the edge.
    task automatic cycle();
        logic rdy_m, do_pop, do_push;
        exp_t h;
        #1;
        rdy_m = rst_done_m && (sb.size() < 2) && !flush;
        chk("a_out_valid", 64'(a_out_valid), 64'(sb.size() != 0));
        chk("b_out_valid", 64'(b_out_valid), 64'(sb.size() != 0));
        chk("a_in_ready", 64'(a_in_ready), 64'(rdy_m));
        chk("b_in_ready", 64'(b_in_ready), 64'(rdy_m));
        chk("a_stat", 64'(a_stat), 64'(stat_a_m));
        chk("b_stat", 64'(b_stat), 64'(stat_b_m));
        do_pop  = reset_n && !flush && out_ready && (sb.size() != 0);
        do_push = reset_n && in_valid && rdy_m;
        if (do_pop) begin
            h = sb.pop_front();
            chk("a_base", a_out_base_pc, h.base);
            chk("b_base", b_out_base_pc, h.base);
            chk("a_trig", a_out_trigger_pc, h.trig);
            chk("b_trig", b_out_trigger_pc, h.trig);
            chk("a_target", a_out_target, h.tgt_a);
            chk("b_target", b_out_target, h.tgt_b);
            chk("a_taken", 64'(a_out_taken), 64'(h.taken));
            chk("b_taken", 64'(b_out_taken), 64'(h.taken));
            chk("a_slot", 64'(a_out_slot), 64'(h.slot));
            chk("b_slot", 64'(b_out_slot), 64'(h.slot));
            if (h.taken) begin
                if (stat_a_m != 32'hFFFF_FFFF) stat_a_m = stat_a_m + 32'd1;
                if (stat_b_m != 32'hFFFF_FFFF) stat_b_m = stat_b_m + 32'd1;
            end
        end
        if (do_push) sb.push_back(cur_exp);
        accepted = do_push;
        @(posedge clock);
        if (!reset_n) begin
            sb.delete();
            stat_a_m = 32'h0;
            stat_b_m = B_STAT_RST;
        end else if (flush) begin
            sb.delete();
        end
        rst_done_m = reset_n;
        @(negedge clock);
    endtask

    task automatic drive_beat(input logic [63:0] pc, input logic [31:0] bht,
                              input logic [3:0] start, input logic hit,
                              input logic [31:0] tgt);
        in_valid      = 1'b1;
        in_pc         = pc;
        in_bht        = bht;
        in_start_slot = start;
        in_tag_hit    = hit;
        in_btb_tgt    = tgt;
        cur_exp       = model(pc, bht, start, hit, tgt);
    endtask

    task automatic send(input logic [63:0] pc, input logic [31:0] bht,
                        input logic [3:0] start, input logic hit,
                        input logic [31:0] tgt);
        drive_beat(pc, bht, start, hit, tgt);
        accepted = 1'b0;
        for (int k = 0; k < 6 && !accepted; k++) cycle();
        chk("send_accept", 64'(accepted), 64'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_pc = '0; in_bht = '0; in_start_slot = '0; in_tag_hit = 1'b0; in_btb_tgt = '0;
        stat_a_m = 32'h0; stat_b_m = B_STAT_RST; rst_done_m = 1'b0; accepted = 1'b0;
        cur_exp = model(64'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);

        // Reset state, then in_ready the first cycle after reset_n is sampled high
        cycle();
        reset_n = 1'b1;
        cycle();
        chk("ready_after_reset", 64'(a_in_ready), 64'd1);

        // First taken slot from start 0
        send(64'h8000_0000, 32'h0000_C080, 4'd0, 1'b1, 32'h1234);
        chk("s0_taken", 64'(a_out_taken), 64'd1);
        chk("s0_slot", 64'(a_out_slot), 64'd3);
        chk("s0_trig", a_out_trigger_pc, 64'h8000_000C);
        chk("s0_target", a_out_target, 64'h1234);
        cycle();

        // Start slot skips slot 3
        send(64'h8000_0000, 32'h0000_C080, 4'd4, 1'b1, 32'h1234);
        chk("s4_slot", 64'(a_out_slot), 64'd7);
        chk("s4_trig", a_out_trigger_pc, 64'h8000_001C);
        cycle();

        // Tag miss clears everything but the base PC
        send(64'h8000_0000, 32'h0000_C080, 4'd0, 1'b0, 32'h1234);
        chk("miss_taken", 64'(a_out_taken), 64'd0);
        chk("miss_trig", a_out_trigger_pc, 64'd0);
        chk("miss_target", a_out_target, 64'd0);
        chk("miss_base", a_out_base_pc, 64'h8000_0000);
        cycle();

        // Concatenated target against zero-extended target
        send(64'hFFFF_FFFF_0000_0000, 32'h0000_0002, 4'd0, 1'b1, 32'h40);
        chk("cat_target", b_out_target, 64'hFFFF_FFFF_0000_0040);
        chk("zext_target", a_out_target, 64'h40);
        cycle();

        // Last slot with trigger PC wrapping past 2^64
        send(64'hFFFF_FFFF_FFFF_FFF0, 32'hC000_0000, 4'd15, 1'b1, 32'h99);
        chk("wrap_slot", 64'(a_out_slot), 64'd15);
        chk("wrap_trig", a_out_trigger_pc, 64'h2C);
        cycle();

        // Weak-not-taken counters everywhere never predict taken
        send(64'h4000, 32'h5555_5555, 4'd0, 1'b1, 32'h77);
        chk("weak_taken", 64'(a_out_taken), 64'd0);
        cycle();

        // Random beats with random back-pressure
        for (int n = 0; n < 24; n++) begin
            drive_beat({$urandom, $urandom}, $urandom, 4'($urandom_range(0, 15)),
                       ($urandom_range(0, 3) != 0), $urandom);
            out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();

        // Back-pressure: FIFO fills at two, head holds, order kept on drain
        out_ready = 1'b0;
        send(64'h1000, 32'h0000_0003, 4'd0, 1'b1, 32'hA1);
        send(64'h2000, 32'h0000_0030, 4'd0, 1'b1, 32'hA2);
        chk("full_not_ready", 64'(a_in_ready), 64'd0);
        drive_beat(64'h3000, 32'h0000_0300, 4'd0, 1'b1, 32'hA3);
        held_base = 64'h1000;
        repeat (3) cycle();
        chk("full_no_accept", 64'(accepted), 64'd0);
        chk("held_base", a_out_base_pc, held_base);
        chk("held_slot", 64'(a_out_slot), 64'd0);
        out_ready = 1'b1;
        cycle();
        chk("full_pop_no_accept", 64'(accepted), 64'd0);
        cycle();
        chk("third_accept", 64'(accepted), 64'd1);
        in_valid = 1'b0;
        repeat (2) cycle();

        // Flush with two buffered beats and a beat on the input
        out_ready = 1'b0;
        send(64'h5000, 32'h0000_0003, 4'd0, 1'b1, 32'hB1);
        send(64'h6000, 32'h0000_0003, 4'd0, 1'b1, 32'hB2);
        drive_beat(64'h7000, 32'h0000_0003, 4'd0, 1'b1, 32'hB3);
        flush     = 1'b1;
        out_ready = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_empty", 64'(a_out_valid), 64'd0);
        repeat (3) cycle();

        // Reset mid-operation discards the buffered beat
        out_ready = 1'b0;
        send(64'h9000, 32'h0000_0003, 4'd0, 1'b1, 32'hC1);
        reset_n   = 1'b0;
        out_ready = 1'b1;
        cycle();
        reset_n = 1'b1;
        chk("midrst_valid", 64'(a_out_valid), 64'd0);
        chk("midrst_stat_b", 64'(b_stat), 64'(B_STAT_RST));
        cycle();

        // Counter saturation after three consumed taken beats
        for (int n = 0; n < 3; n++) begin
            send(64'hA000 + 64'(n * 64), 32'h0000_000C, 4'd0, 1'b1, 32'hD0);
            cycle();
        end
        chk("sat_stat_b", 64'(b_stat), 64'hFFFF_FFFF);
        chk("count_stat_a", 64'(a_stat), 64'd3);
        cycle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/bhtbtb_pred_stage.md
BHTBTB_PRED_STAGE -- requirements
Module: bhtbtb_pred_stage

Interface
REQ-001 The block SHALL have parameter SLOTS, default 16, giving the number of instruction slots per fetch block (power of 2, 2..32).
REQ-002 The block SHALL have parameter CNT_W, default 2, giving the width of each saturating counter.
REQ-003 The block SHALL have parameter PC_W, default 64, giving the PC width.
REQ-004 The block SHALL have parameter TGT_W, default 32, giving the BTB target width (TGT_W <= PC_W).
REQ-005 The block SHALL have parameter INST_BYTES, default 4, giving the byte stride per slot.
REQ-006 The block SHALL have parameter TGT_MODE, default 0: 0 = zero-extend target, 1 = concatenate target with base-PC upper bits.
REQ-007 The block SHALL have these ports:
- clock  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  kill all buffered predictions.
- in_valid  in  1  BHT/BTB read beat valid.
- in_ready  out  1  stage can accept a beat.
- in_bht  in  SLOTS*CNT_W  counters; slot i at bits [i*CNT_W +: CNT_W].
- in_btb_tgt  in  TGT_W  predicted target.
- in_tag_hit  in  1  BTB tag hit.
- in_pc  in  PC_W  fetch-block base PC.
- in_start_slot  in  log2(SLOTS)  first live slot of the block.
- out_valid  out  1  prediction available.
- out_ready  in  1  consumer accepts.
- out_base_pc  out  PC_W  base PC of the beat.
- out_trigger_pc  out  PC_W  PC of the predicted-taken slot.
- out_target  out  PC_W  predicted target.
- out_taken  out  1  taken prediction.
- out_slot  out  log2(SLOTS)  index of the taken slot.
- stat_taken_cnt  out  32  number of consumed taken predictions.

Function
REQ-008 A beat SHALL be accepted when in_valid and in_ready are both high in a cycle with flush low.
REQ-009 Slot i SHALL be eligible when i >= in_start_slot and counter >= 2^(CNT_W-1).
REQ-010 The taken result SHALL be the lowest-index eligible slot, qualified by in_tag_hit; with tag miss or no eligible slot: out_taken=0, out_slot=0, out_trigger_pc=0, out_target=0.
REQ-011 On taken: out_trigger_pc SHALL be (in_pc + slot*INST_BYTES) mod 2^PC_W.
REQ-012 On taken: out_target SHALL be {zeros, in_btb_tgt} for TGT_MODE=0, or {in_pc[PC_W-1:TGT_W], in_btb_tgt} for TGT_MODE=1.
REQ-013 out_base_pc SHALL equal in_pc for every beat, whether taken or not.
REQ-014 The scan result SHALL be written into a 2-entry FIFO; out_valid SHALL assert the cycle after acceptance (1-cycle latency), with no combinational in-to-out path.
REQ-015 in_ready SHALL equal (occupancy < 2) and not flush, so a full FIFO does not accept a beat even with a simultaneous pop.
REQ-016 out_valid SHALL equal (occupancy != 0); the head and its data SHALL be held stable while out_valid and not out_ready.
REQ-017 A simultaneous push and pop SHALL leave the occupancy unchanged with FIFO order preserved.
REQ-018 Read and write pointers SHALL wrap modulo 2.
REQ-019 A flush SHALL clear the occupancy to 0 at the next edge, drop any same-cycle beat, and not count a same-cycle pop.
REQ-020 stat_taken_cnt SHALL increment on out_valid & out_ready & out_taken with flush low, and saturate at 0xFFFFFFFF.
REQ-021 stat_taken_cnt SHALL be unaffected by flush.

Reset
REQ-022 While reset_n is low at a clock edge: occupancy, pointers and stat_taken_cnt SHALL go to 0, out_valid SHALL be 0, in_ready SHALL be 0, and all FIFO data SHALL be 0.
REQ-023 A reset asserted mid-operation SHALL discard buffered beats with no output handshake.
REQ-024 in_ready SHALL return high the first cycle after reset_n is sampled high.

Structure
REQ-025 Package bpu_pkg SHALL hold the default parameter constants, the TGT_MODE encodings and the prediction-entry struct (base_pc, trigger_pc, target, taken, slot).
REQ-026 The first-taken scan SHALL be the sub-module bpu_first_taken_enc (combinational, parametrised by SLOTS and CNT_W, outputs found and index).
REQ-027 The FIFO and the counter SHALL reside in bhtbtb_pred_stage.

Verification
REQ-028 Scenario: pc=0x8000_0000, start=0, counters slot3=2'b10 and slot7=2'b11, tag hit, tgt=0x1234 -> next cycle: taken=1, slot=3, trigger=0x8000_000C, target=0x1234.
REQ-029 Scenario: same beat with start=4 -> slot=7, trigger=0x8000_001C; same beat with tag miss -> taken=0, trigger=0, target=0, base=0x8000_0000.
REQ-030 Scenario: TGT_MODE=1, pc=0xFFFF_FFFF_0000_0000, tgt=0x40 -> target=0xFFFF_FFFF_0000_0040.
REQ-031 Scenario: hold out_ready=0 and push 3 beats -> in_ready=0 after 2 beats, first beat held stable; then out_ready=1 -> beats emerge in order.
REQ-032 Scenario: flush with 2 beats buffered and an in_valid beat present -> out_valid=0 next cycle, stat unchanged, the dropped beat never appears.
REQ-033 Scenario: preload stat_taken_cnt to 0xFFFF_FFFE, consume 3 taken beats -> stat holds at 0xFFFF_FFFF.
